// File: rtl/mem_ctrl_if.sv
// Bus bundle between the load/store stage, the instruction fetch unit and the
// byte-wide RAM. mem_ctrl uses the slave side; the surrounding system drives master.
interface mem_ctrl_if;
    logic [1:0]  memctl_op;
    logic [1:0]  memctl_len;
    logic [31:0] memctl_addr;
    logic [31:0] memctl_data;
    logic        memctl_fin;
    logic [31:0] memctl_out;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_fin;
    logic [31:0] if_data;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din;

    modport slave (
        input  memctl_op, memctl_len, memctl_addr, memctl_data,
        input  if_req, if_addr, mem_din,
        output memctl_fin, memctl_out, if_fin, if_data,
        output mem_a, mem_dout, mem_wr
    );

    modport master (
        output memctl_op, memctl_len, memctl_addr, memctl_data,
        output if_req, if_addr, mem_din,
        input  memctl_fin, memctl_out, if_fin, if_data,
        input  mem_a, mem_dout, mem_wr
    );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates load/store and instruction fetch
// requests onto a single 8-bit RAM port with one cycle of read latency.
module mem_ctrl (
    input  logic      clk_in,
    input  logic      rst_in,
    input  logic      rdy_in,
    mem_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SAVE = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic        owner_if_reg;
    logic [2:0]  n_reg;
    logic [2:0]  cnt_reg;
    logic [2:0]  cnt_inc;
    logic [23:0] data_reg;
    logic [31:0] buf_reg;
    logic [31:0] load_word;
    logic [31:0] memctl_out_reg;
    logic [31:0] if_data_reg;
    logic [31:0] mem_a_reg;
    logic [7:0]  mem_dout_reg;
    logic [7:0]  save_byte_next;
    logic [2:0]  len_bytes;
    logic        mem_load;
    logic        mem_save;
    logic        fetch;
    logic        accept;

    assign mem_load = (bus.memctl_op == 2'b01);
    assign mem_save = (bus.memctl_op == 2'b10);
    assign fetch    = bus.if_req && !mem_load && !mem_save;
    assign accept   = (state_reg == IDLE) && (mem_load || mem_save || bus.if_req);
    assign cnt_inc  = cnt_reg + 3'd1;

    always_comb begin
        len_bytes = 3'd4;
        if (!fetch) begin
            case (bus.memctl_len)
                2'b00:   len_bytes = 3'd1;
                2'b01:   len_bytes = 3'd2;
                default: len_bytes = 3'd4;
            endcase
        end
    end

    // In LOAD cycle k the RAM returns byte k-1; merge it into the accumulated word.
    for (genvar gi = 0; gi < 4; gi++) begin : g_load_byte
        assign load_word[8*gi +: 8] = (cnt_reg == 3'(gi + 1)) ? bus.mem_din
                                                              : buf_reg[8*gi +: 8];
    end

    // Byte 0 goes out at acceptance; this picks byte cnt+1 for the next issue cycle.
    always_comb begin
        case (cnt_reg)
            3'd0:    save_byte_next = data_reg[7:0];
            3'd1:    save_byte_next = data_reg[15:8];
            default: save_byte_next = data_reg[23:16];
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_reg <= IDLE;
        end else if (rdy_in) begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (mem_save) begin
                    state_next = SAVE;
                end else if (mem_load || bus.if_req) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (cnt_reg == n_reg) begin
                    state_next = DONE;
                end
            end
            SAVE: begin
                if (cnt_inc == n_reg) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Strobes are qualified by rdy_in so a stall never repeats a write or a pulse.
    always_comb begin
        bus.mem_wr     = 1'b0;
        bus.memctl_fin = 1'b0;
        bus.if_fin     = 1'b0;
        if (rdy_in) begin
            case (state_reg)
                SAVE: bus.mem_wr = 1'b1;
                DONE: begin
                    bus.memctl_fin = !owner_if_reg;
                    bus.if_fin     = owner_if_reg;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            owner_if_reg   <= 1'b0;
            n_reg          <= 3'd0;
            cnt_reg        <= 3'd0;
            data_reg       <= 24'd0;
            buf_reg        <= 32'd0;
            memctl_out_reg <= 32'd0;
            if_data_reg    <= 32'd0;
            mem_a_reg      <= 32'd0;
            mem_dout_reg   <= 8'd0;
        end else if (rdy_in) begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        owner_if_reg <= fetch;
                        n_reg        <= len_bytes;
                        cnt_reg      <= 3'd0;
                        buf_reg      <= 32'd0;
                        data_reg     <= bus.memctl_data[31:8];
                        mem_a_reg    <= fetch ? bus.if_addr : bus.memctl_addr;
                        if (mem_save) begin
                            mem_dout_reg <= bus.memctl_data[7:0];
                        end
                    end
                end
                LOAD: begin
                    cnt_reg <= cnt_inc;
                    buf_reg <= load_word;
                    if (cnt_inc < n_reg) begin
                        mem_a_reg <= mem_a_reg + 32'd1;
                    end
                    if (cnt_reg == n_reg) begin
                        if (owner_if_reg) begin
                            if_data_reg <= load_word;
                        end else begin
                            memctl_out_reg <= load_word;
                        end
                    end
                end
                SAVE: begin
                    cnt_reg <= cnt_inc;
                    if (cnt_inc < n_reg) begin
                        mem_a_reg    <= mem_a_reg + 32'd1;
                        mem_dout_reg <= save_byte_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.memctl_out = memctl_out_reg;
    assign bus.if_data    = if_data_reg;
    assign bus.mem_a      = mem_a_reg;
    assign bus.mem_dout   = mem_dout_reg;
endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: table of single transactions plus
// hand-written sequences for arbitration, stalls and mid-transfer reset.
module tb_mem_ctrl;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rdy   = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic [31:0] last_mem_out = 32'd0;

    mem_ctrl_if bus ();

    mem_ctrl dut (
        .clk_in (clk),
        .rst_in (rst_n),
        .rdy_in (rdy),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Byte RAM model, frozen by rdy like the real one; logs every write.
    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
        int          cyc;
    } wr_t;
    logic [7:0] ram [logic [31:0]];
    wr_t wr_log[$];

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : 8'h00;
    endfunction

    always @(posedge clk) begin
        if (rdy) begin
            if (bus.mem_wr) begin
                ram[bus.mem_a] = bus.mem_dout;
                wr_log.push_back('{bus.mem_a, bus.mem_dout, cyc});
            end
            bus.mem_din <= ram_rd(bus.mem_a);
        end
    end

    // Scoreboard of expected completions.
    typedef struct {
        bit          is_if;
        logic [31:0] val;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] got;
        #1;
        if (rst_n) begin
            if (bus.memctl_fin || bus.if_fin) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_fin cyc=%0d memctl_fin=%b if_fin=%b required none",
                             cyc, bus.memctl_fin, bus.if_fin);
                end else begin
                    e   = sb.pop_front();
                    got = e.is_if ? bus.if_data : bus.memctl_out;
                    if (bus.if_fin !== e.is_if || got !== e.val || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL fin owner_if=%b data=%h cyc=%0d required owner_if=%b data=%h cyc=%0d",
                                 bus.if_fin, got, cyc, e.is_if, e.val, e.cyc);
                    end else begin
                        $display("PASS fin owner_if=%b data=%h cyc=%0d", e.is_if, got, cyc);
                    end
                end
            end
            if (!rdy) begin
                checks++;
                if (bus.mem_wr !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_mem_wr got=%b required 0 cyc=%0d", bus.mem_wr, cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h required=%h", name, got, exp);
        end
    endtask

    task automatic wait_fin(input bit is_if, input int t0, input int stall_at, input int stall_len);
        bit seen = 1'b0;
        for (int k = 0; k < 64 && !seen; k++) begin
            @(negedge clk);
            if (stall_len > 0) begin
                if (cyc - t0 == stall_at) rdy = 1'b0;
                if (cyc - t0 == stall_at + stall_len) rdy = 1'b1;
            end
            seen = is_if ? bus.if_fin : bus.memctl_fin;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL timeout owner_if=%b got no fin required fin within 64 cycles", is_if);
            sb.delete();
            rdy = 1'b1;
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [1:0] len, input logic [31:0] addr,
                         input logic [31:0] data, input bit is_if, input logic [31:0] exp_val,
                         input int lat, input int stall_at, input int stall_len, output int t0);
        @(negedge clk);
        t0 = cyc;
        wr_log.delete();
        if (is_if) begin
            bus.if_req  = 1'b1;
            bus.if_addr = addr;
            sb.push_back('{1'b1, exp_val, t0 + lat});
        end else begin
            bus.memctl_op   = op;
            bus.memctl_len  = len;
            bus.memctl_addr = addr;
            bus.memctl_data = data;
            if (op == 2'b01) last_mem_out = exp_val;
            sb.push_back('{1'b0, last_mem_out, t0 + lat});
        end
        wait_fin(is_if, t0, stall_at, stall_len);
        bus.memctl_op = 2'b00;
        bus.if_req    = 1'b0;
    endtask

    task automatic check_writes(input string name, input logic [31:0] addr, input logic [31:0] data,
                                input int n, input int t0, input bit chk_cyc);
        logic [31:0] d;
        checks++;
        if (wr_log.size() != n) begin
            errors++;
            $display("FAIL %s_write_count got=%0d required=%0d", name, wr_log.size(), n);
        end
        for (int i = 0; i < n && i < wr_log.size(); i++) begin
            d = data >> (8 * i);
            checks++;
            if (wr_log[i].addr !== addr + 32'(i) || wr_log[i].data !== d[7:0] ||
                (chk_cyc && wr_log[i].cyc != t0 + 1 + i)) begin
                errors++;
                $display("FAIL %s_write%0d got a=%h d=%h cyc=%0d required a=%h d=%h cyc=%0d",
                         name, i, wr_log[i].addr, wr_log[i].data, wr_log[i].cyc,
                         addr + 32'(i), d[7:0], t0 + 1 + i);
            end
        end
    endtask

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [1:0]  len;
        logic [31:0] addr;
        logic [31:0] data;
        bit          is_if;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    initial begin
        vec_t vecs[10];
        int   t0;
        int   n;

        vecs[0] = '{"lw_100",  2'b01, 2'b00, 32'h0000_0100, 32'h0,         1'b0, 32'h4433_2211, 6};
        vecs[0].len = 2'b10;
        vecs[1] = '{"sb_20",   2'b10, 2'b00, 32'h0000_0020, 32'hDEAD_BEEF, 1'b0, 32'h0,         2};
        vecs[2] = '{"lb_101",  2'b01, 2'b00, 32'h0000_0101, 32'h0,         1'b0, 32'h0000_0022, 3};
        vecs[3] = '{"lh_102",  2'b01, 2'b01, 32'h0000_0102, 32'h0,         1'b0, 32'h0000_4433, 4};
        vecs[4] = '{"sh_wrap", 2'b10, 2'b01, 32'hFFFF_FFFF, 32'h0000_ABCD, 1'b0, 32'h0,         3};
        vecs[5] = '{"lh_wrap", 2'b01, 2'b01, 32'hFFFF_FFFF, 32'h0,         1'b0, 32'h0000_ABCD, 4};
        vecs[6] = '{"sw_200",  2'b10, 2'b10, 32'h0000_0200, 32'h0102_0304, 1'b0, 32'h0,         5};
        vecs[7] = '{"if_200",  2'b00, 2'b00, 32'h0000_0200, 32'h0,         1'b1, 32'h0102_0304, 6};
        vecs[8] = '{"lw11_101",2'b01, 2'b11, 32'h0000_0101, 32'h0,         1'b0, 32'h9944_3322, 6};
        vecs[9] = '{"lb_20",   2'b01, 2'b00, 32'h0000_0020, 32'h0,         1'b0, 32'h0000_00EF, 3};

        ram[32'h100] = 8'h11;
        ram[32'h101] = 8'h22;
        ram[32'h102] = 8'h33;
        ram[32'h103] = 8'h44;
        ram[32'h104] = 8'h99;

        bus.memctl_op   = 2'b00;
        bus.memctl_len  = 2'b00;
        bus.memctl_addr = 32'h0;
        bus.memctl_data = 32'h0;
        bus.if_req      = 1'b0;
        bus.if_addr     = 32'h0;

        // Reset values
        repeat (3) @(negedge clk);
        #1;
        chk("rst_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
        chk("rst_mem_a", bus.mem_a, 32'd0);
        chk("rst_mem_dout", {24'd0, bus.mem_dout}, 32'd0);
        chk("rst_fins", {30'd0, bus.memctl_fin, bus.if_fin}, 32'd0);
        chk("rst_memctl_out", bus.memctl_out, 32'd0);
        chk("rst_if_data", bus.if_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 10; v++) begin
            issue(vecs[v].op, vecs[v].len, vecs[v].addr, vecs[v].data, vecs[v].is_if,
                  vecs[v].exp, vecs[v].lat, 0, 0, t0);
            n = (vecs[v].len == 2'b00) ? 1 : (vecs[v].len == 2'b01) ? 2 : 4;
            if (vecs[v].op == 2'b10 && !vecs[v].is_if)
                check_writes(vecs[v].name, vecs[v].addr, vecs[v].data, n, t0, 1'b1);
            else
                check_writes(vecs[v].name, vecs[v].addr, vecs[v].data, 0, t0, 1'b1);
        end

        // op=11 behaves as NONE: no writes, no completion
        @(negedge clk);
        wr_log.delete();
        bus.memctl_op   = 2'b11;
        bus.memctl_len  = 2'b10;
        bus.memctl_addr = 32'h100;
        repeat (6) @(negedge clk);
        bus.memctl_op = 2'b00;
        chk("op11_writes", wr_log.size(), 32'd0);

        // MEM and IF requests in the same IDLE cycle
        @(negedge clk);
        t0 = cyc;
        bus.memctl_op   = 2'b01;
        bus.memctl_len  = 2'b01;
        bus.memctl_addr = 32'h100;
        bus.if_req      = 1'b1;
        bus.if_addr     = 32'h100;
        last_mem_out    = 32'h0000_2211;
        sb.push_back('{1'b0, 32'h0000_2211, t0 + 4});
        sb.push_back('{1'b1, 32'h4433_2211, t0 + 11});
        wait_fin(1'b0, t0, 0, 0);
        bus.memctl_op = 2'b00;
        wait_fin(1'b1, t0, 0, 0);
        bus.if_req = 1'b0;
        repeat (4) @(negedge clk);
        chk("memctl_out_held", bus.memctl_out, 32'h0000_2211);

        // Three-cycle rdy stall in the middle of a word load
        issue(2'b01, 2'b10, 32'h100, 32'h0, 1'b0, 32'h4433_2211, 9, 2, 3, t0);
        check_writes("lw_stall", 32'h100, 32'h0, 0, t0, 1'b0);

        // Reset while the third byte of a word store is on the bus
        @(negedge clk);
        t0 = cyc;
        wr_log.delete();
        bus.memctl_op   = 2'b10;
        bus.memctl_len  = 2'b10;
        bus.memctl_addr = 32'h300;
        bus.memctl_data = 32'h5566_7788;
        for (int k = 0; k < 10 && cyc - t0 < 3; k++) @(negedge clk);
        chk("sw_byte2_wr", {31'd0, bus.mem_wr}, 32'd1);
        chk("sw_byte2_a", bus.mem_a, 32'h302);
        chk("sw_byte2_dout", {24'd0, bus.mem_dout}, 32'h66);
        rst_n = 1'b0;
        #1;
        chk("abort_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
        chk("abort_mem_a", bus.mem_a, 32'd0);
        chk("abort_mem_dout", {24'd0, bus.mem_dout}, 32'd0);
        chk("abort_fin", {31'd0, bus.memctl_fin}, 32'd0);
        chk("abort_memctl_out", bus.memctl_out, 32'd0);
        chk("abort_if_data", bus.if_data, 32'd0);
        bus.memctl_op = 2'b00;
        last_mem_out  = 32'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_writes("sw_abort", 32'h300, 32'h5566_7788, 2, t0, 1'b1);
        issue(2'b01, 2'b00, 32'h301, 32'h0, 1'b0, 32'h0000_0077, 3, 0, 0, t0);
        check_writes("lb_after_rst", 32'h301, 32'h0, 0, t0, 1'b1);

        repeat (4) @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish required finish before 200000");
        $fatal(1);
    end
endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have port clk_in, input, 1: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_in, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port rdy_in, input, 1: global enable; low freezes block.
REQ-004 SHALL have port memctl_op, input, 2: 00 NONE, 01 LOAD, 10 SAVE, 11 treated as NONE.
REQ-005 SHALL have port memctl_len, input, 2: 00 byte, 01 half, 10 word, 11 treated as word.
REQ-006 SHALL have ports memctl_addr, input, 32 (byte address) and memctl_data, input, 32 (store data).
REQ-007 SHALL have port memctl_fin, output, 1: one-cycle completion pulse to the load/store stage.
REQ-008 SHALL have port memctl_out, output, 32: load result, zero-extended, little-endian.
REQ-009 SHALL have ports if_req, input, 1 and if_addr, input, 32: instruction fetch request.
REQ-010 SHALL have ports if_fin, output, 1 (one-cycle pulse) and if_data, output, 32 (fetched word).
REQ-011 SHALL have ports mem_a, output, 32 (RAM byte address) and mem_dout, output, 8 (write byte).
REQ-012 SHALL have ports mem_wr, output, 1 (1 = write) and mem_din, input, 8 (read byte, one cycle after mem_a).

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, SAVE, DONE.
REQ-014 IDLE SHALL accept a request: LOAD/SAVE on memctl_op first, else if_req as a 4-byte LOAD; capture addr, len, data and owner (MEM or IF).
REQ-015 MEM request and if_req both valid in IDLE: MEM SHALL win; if_req served on a later IDLE.
REQ-016 Requests arriving outside IDLE SHALL be ignored; requesters hold inputs until their fin.
REQ-017 Byte count N SHALL be 1/2/4 per len; byte i uses address addr+i with 32-bit wrap-around.
REQ-018 LOAD, request seen in IDLE cycle T0: mem_a=addr+i, mem_wr=0 in cycle T0+1+i; mem_din sampled at end of cycle T0+2+i into result byte i.
REQ-019 LOAD SHALL reach DONE in cycle T0+N+2; unloaded upper bytes of the result SHALL be 0.
REQ-020 SAVE, request in T0: mem_a=addr+i, mem_dout=data[8i+7:8i], mem_wr=1 in cycle T0+1+i; DONE in cycle T0+N+1.
REQ-021 DONE SHALL last exactly one cycle, then go to IDLE; new requests are sampled from that IDLE cycle.
REQ-022 memctl_fin SHALL be 1 only in DONE with owner MEM; if_fin only in DONE with owner IF.
REQ-023 memctl_out and if_data SHALL be registered, valid from their fin cycle, and held until the next load by the same owner completes.
REQ-024 mem_wr SHALL be 1 only in SAVE issue cycles; it SHALL be 0 in IDLE, LOAD and DONE.
REQ-025 rdy_in low SHALL freeze all registers and force mem_wr=0; mem_a and mem_dout hold.
REQ-026 The RAM is frozen by the same rdy_in, so read alignment SHALL be preserved across rdy_in stalls, with no byte lost or duplicated.
REQ-027 Store bytes SHALL be written in ascending address order, each exactly once.

Reset
REQ-028 rst_in low SHALL immediately force: state IDLE, memctl_fin=0, if_fin=0, mem_wr=0, mem_a=0, mem_dout=0, memctl_out=0, if_data=0.
REQ-029 Reset during LOAD/SAVE SHALL abort it with no fin and no further writes; first acceptance occurs in the IDLE cycle after rst_in rises.

Verification
REQ-030 LW at 0x100, RAM bytes 11 22 33 44 -> mem_a 0x100..0x103 on T0+1..T0+4; memctl_fin in T0+6; memctl_out=0x44332211.
REQ-031 SB addr 0x20, data 0xDEADBEEF -> exactly one write cycle (T0+1): mem_a=0x20, mem_dout=0xEF; memctl_fin in T0+2.
REQ-032 LOAD len=01 with if_req=1 in the same IDLE cycle -> MEM served first (fin in T0+4); IF fetch starts in the IDLE after DONE; if_fin pulses once.
REQ-033 SH at 0xFFFFFFFF, data 0xABCD -> writes 0xCD at 0xFFFFFFFF, then 0xAB at 0x00000000.
REQ-034 rdy_in low 3 cycles mid-LW -> fin delayed by exactly 3 cycles; result bytes correct; mem_wr=0 throughout.
REQ-035 rst_in low during SW byte 2 -> mem_wr=0 at once; no memctl_fin; after release a new LB completes normally.
